// File: rtl/array_17_arbiter_if.sv
// Requester-side bundle for array_17_arbiter: one read requester with response, one write requester.
interface array_17_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 80,
  parameter int unsigned MASK_W = 10
);
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rd_resp_data;
  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [DATA_W-1:0] wr_req_data;
  logic [MASK_W-1:0] wr_req_mask;

  modport master (
    output rd_req_valid, rd_req_addr,
    input  rd_req_ready, rd_resp_valid, rd_resp_data,
    output wr_req_valid, wr_req_addr, wr_req_data, wr_req_mask,
    input  wr_req_ready
  );

  modport slave (
    input  rd_req_valid, rd_req_addr,
    output rd_req_ready, rd_resp_valid, rd_resp_data,
    input  wr_req_valid, wr_req_addr, wr_req_data, wr_req_mask,
    output wr_req_ready
  );
endinterface

// File: rtl/array_17_arbiter.sv
// Single-port RW arbiter for the 4096x80 byte-masked array; read vs write with starvation guard.
// Define ARRAY17_INIT_EN to zero-fill the whole array after reset before any grant.
module array_17_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 80,
  parameter int unsigned MASK_W     = 10,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  array_17_arbiter_if.slave req_if,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              init_done
);

  localparam int unsigned CNT_W = 3;

  logic              in_init;
  logic [ADDR_W-1:0] init_ptr;
  logic              rd_gnt;
  logic              wr_gnt;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              rd_resp_valid_q, rd_resp_valid_d;

`ifdef ARRAY17_INIT_EN
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  // Clear sweep: one address per cycle, leave INIT after the last one.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + ADDR_W'(1);
      if (init_ptr_q == '1) state_d = ST_RUN;
    end
  end

  assign in_init   = (state_q == ST_INIT);
  assign init_ptr  = init_ptr_q;
  assign init_done = (state_q == ST_RUN);
`else
  assign in_init   = 1'b0;
  assign init_ptr  = '0;
  assign init_done = 1'b1;
`endif

  // Write wins ties unless the reader has lost STARVE_MAX arbitrations in a row.
  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (reset_n && !in_init) begin
      if (req_if.wr_req_valid &&
          !(req_if.rd_req_valid && (starve_q == CNT_W'(STARVE_MAX)))) begin
        wr_gnt = 1'b1;
      end else if (req_if.rd_req_valid) begin
        rd_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (in_init) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_ptr;
      sram_wmask = '1;
    end else if (wr_gnt) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = req_if.wr_req_addr;
      sram_wmask = req_if.wr_req_mask;
      sram_wdata = req_if.wr_req_data;
    end else if (rd_gnt) begin
      sram_en    = 1'b1;
      sram_addr  = req_if.rd_req_addr;
    end
  end

  always_comb begin
    starve_d        = starve_q;
    rd_resp_valid_d = rd_gnt;
    if (rd_gnt) begin
      starve_d = '0;
    end else if (req_if.rd_req_valid && (starve_q != CNT_W'(STARVE_MAX))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_q        <= '0;
      rd_resp_valid_q <= 1'b0;
    end else begin
      starve_q        <= starve_d;
      rd_resp_valid_q <= rd_resp_valid_d;
    end
  end

  assign req_if.rd_req_ready  = rd_gnt;
  assign req_if.wr_req_ready  = wr_gnt;
  assign req_if.rd_resp_valid = rd_resp_valid_q;
  assign req_if.rd_resp_data  = sram_rdata;

endmodule

// File: tb/tb_array_17_arbiter.sv
// Directed bench for array_17_arbiter with a behavioural 1-cycle-latency byte-masked array.
module tb_array_17_arbiter;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 80;
  localparam int unsigned MASK_W = 10;

  localparam logic [79:0] D1     = 80'hFFEE_DDCC_BBAA_9988_7766;
  localparam logic [79:0] ONES   = {80{1'b1}};
  localparam logic [79:0] MASKED = 80'hFFFF_FFFF_FFFF_FFFF_FF00;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_wmode;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic              init_done;

  int checks   = 0;
  int failures = 0;

  array_17_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  array_17_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .STARVE_MAX(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_if     (bus),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .init_done  (init_done)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0] mem [0:4095];

  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int b = 0; b < 10; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic        rd_v;
    logic [11:0] rd_a;
    logic        wr_v;
    logic [11:0] wr_a;
    logic [79:0] wr_d;
    logic [9:0]  wr_m;
    logic        e_rrdy;
    logic        e_wrdy;
    logic        e_en;
    logic        e_wm;
    logic [11:0] e_addr;
    logic [9:0]  e_wmask;
    logic        e_rv;
    logic [79:0] e_rd;
  } vec_t;

  localparam int NV = 17;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [11:0] ra, input logic wv,
                       input logic [11:0] wa, input logic [79:0] wd, input logic [9:0] wm);
    bus.rd_req_valid = rv;
    bus.rd_req_addr  = ra;
    bus.wr_req_valid = wv;
    bus.wr_req_addr  = wa;
    bus.wr_req_data  = wd;
    bus.wr_req_mask  = wm;
  endtask

  // Called right after reset release, at a sampling point.
  task automatic wait_init(input string tag);
`ifdef ARRAY17_INIT_EN
    int n = 0;
    bit ok = 1'b1;
    while (!init_done && n < 5000) begin
      if (!(sram_en && sram_wmode && sram_wmask == '1 && sram_wdata == '0 &&
            sram_addr == 12'(n))) ok = 1'b0;
      @(negedge clock);
      #1;
      n++;
    end
    chk({tag, "_init_cycles"}, 80'(n), 80'd4096);
    chk({tag, "_init_sweep"}, 80'(ok), 80'd1);
`else
    chk({tag, "_init_done"}, 80'(init_done), 80'd1);
`endif
  endtask

  initial begin
    vec[0]  = '{0, 12'h000, 0, 12'h000, 80'h0, 10'h000, 0, 0, 0, 0, 12'h000, 10'h000, 0, 80'h0};
    vec[1]  = '{0, 12'h000, 1, 12'h123, D1,    10'h3FF, 0, 1, 1, 1, 12'h123, 10'h3FF, 0, 80'h0};
    vec[2]  = '{1, 12'h123, 0, 12'h000, 80'h0, 10'h000, 1, 0, 1, 0, 12'h123, 10'h000, 0, 80'h0};
    vec[3]  = '{0, 12'h000, 0, 12'h000, 80'h0, 10'h000, 0, 0, 0, 0, 12'h000, 10'h000, 1, D1};
    vec[4]  = '{0, 12'h000, 0, 12'h000, 80'h0, 10'h000, 0, 0, 0, 0, 12'h000, 10'h000, 0, 80'h0};
    vec[5]  = '{0, 12'h000, 1, 12'h010, ONES,  10'h3FF, 0, 1, 1, 1, 12'h010, 10'h3FF, 0, 80'h0};
    vec[6]  = '{0, 12'h000, 1, 12'h010, 80'h0, 10'h001, 0, 1, 1, 1, 12'h010, 10'h001, 0, 80'h0};
    vec[7]  = '{1, 12'h010, 0, 12'h000, 80'h0, 10'h000, 1, 0, 1, 0, 12'h010, 10'h000, 0, 80'h0};
    vec[8]  = '{0, 12'h000, 0, 12'h000, 80'h0, 10'h000, 0, 0, 0, 0, 12'h000, 10'h000, 1, MASKED};
    vec[9]  = '{0, 12'h000, 1, 12'h200, 80'h5, 10'h3FF, 0, 1, 1, 1, 12'h200, 10'h3FF, 0, 80'h0};
    vec[10] = '{1, 12'h200, 1, 12'h200, 80'h1, 10'h3FF, 0, 1, 1, 1, 12'h200, 10'h3FF, 0, 80'h0};
    vec[11] = '{1, 12'h200, 0, 12'h000, 80'h0, 10'h000, 1, 0, 1, 0, 12'h200, 10'h000, 0, 80'h0};
    vec[12] = '{0, 12'h000, 0, 12'h000, 80'h0, 10'h000, 0, 0, 0, 0, 12'h000, 10'h000, 1, 80'h1};
    vec[13] = '{1, 12'h123, 0, 12'h000, 80'h0, 10'h000, 1, 0, 1, 0, 12'h123, 10'h000, 0, 80'h0};
    vec[14] = '{1, 12'h010, 0, 12'h000, 80'h0, 10'h000, 1, 0, 1, 0, 12'h010, 10'h000, 1, D1};
    vec[15] = '{0, 12'h000, 0, 12'h000, 80'h0, 10'h000, 0, 0, 0, 0, 12'h000, 10'h000, 1, MASKED};
    vec[16] = '{0, 12'h000, 0, 12'h000, 80'h0, 10'h000, 0, 0, 0, 0, 12'h000, 10'h000, 0, 80'h0};

    // Reset: requests present but nothing may be accepted.
    drive(1, 12'h001, 1, 12'h002, 80'h3, 10'h3FF);
    #3;
    chk("rst_rd_ready", 80'(bus.rd_req_ready), 80'd0);
    chk("rst_wr_ready", 80'(bus.wr_req_ready), 80'd0);
    chk("rst_resp_valid", 80'(bus.rd_resp_valid), 80'd0);
`ifndef ARRAY17_INIT_EN
    chk("rst_sram_en", 80'(sram_en), 80'd0);
`endif
    repeat (2) @(negedge clock);
    drive(0, 12'h000, 0, 12'h000, 80'h0, 10'h000);
    reset_n = 1'b1;
    #1;
    wait_init("boot");

`ifdef ARRAY17_INIT_EN
    @(negedge clock);
    drive(1, 12'h0A5, 0, 12'h000, 80'h0, 10'h000);
    #1;
    chk("init_rd_ready", 80'(bus.rd_req_ready), 80'd1);
    @(negedge clock);
    drive(0, 12'h000, 0, 12'h000, 80'h0, 10'h000);
    #1;
    chk("init_rd_valid", 80'(bus.rd_resp_valid), 80'd1);
    chk("init_rd_zero", bus.rd_resp_data, 80'h0);
`endif

    // Table: one vector per cycle; response fields refer to the previous row's read.
    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      drive(vec[i].rd_v, vec[i].rd_a, vec[i].wr_v, vec[i].wr_a, vec[i].wr_d, vec[i].wr_m);
      #1;
      chk($sformatf("v%0d_rd_ready", i), 80'(bus.rd_req_ready), 80'(vec[i].e_rrdy));
      chk($sformatf("v%0d_wr_ready", i), 80'(bus.wr_req_ready), 80'(vec[i].e_wrdy));
      chk($sformatf("v%0d_sram_en", i), 80'(sram_en), 80'(vec[i].e_en));
      chk($sformatf("v%0d_wmode", i), 80'(sram_wmode), 80'(vec[i].e_wm));
      chk($sformatf("v%0d_wmask", i), 80'(sram_wmask), 80'(vec[i].e_wmask));
      chk($sformatf("v%0d_wdata", i), sram_wdata, (vec[i].e_en && vec[i].e_wm) ? vec[i].wr_d : 80'h0);
      if (vec[i].e_en) chk($sformatf("v%0d_addr", i), 80'(sram_addr), 80'(vec[i].e_addr));
      chk($sformatf("v%0d_resp_valid", i), 80'(bus.rd_resp_valid), 80'(vec[i].e_rv));
      if (vec[i].e_rv) chk($sformatf("v%0d_resp_data", i), bus.rd_resp_data, vec[i].e_rd);
    end

    // Starvation: both valid continuously; read wins every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      drive(1, 12'h050, 1, 12'h300 + 12'(i), 80'(i), 10'h3FF);
      #1;
      chk($sformatf("starve%0d_rd_ready", i), 80'(bus.rd_req_ready), 80'((i % 5) == 4));
      chk($sformatf("starve%0d_wr_ready", i), 80'(bus.wr_req_ready), 80'((i % 5) != 4));
      chk($sformatf("starve%0d_resp_valid", i), 80'(bus.rd_resp_valid), 80'((i % 5) == 0 && i > 0));
    end

    // Starved read beats a same-address write and sees the old contents.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      drive(1, 12'h060, 1, 12'h3F0 + 12'(i), 80'h9, 10'h3FF);
      #1;
      chk($sformatf("pre%0d_wr_ready", i), 80'(bus.wr_req_ready), 80'd1);
    end
    @(negedge clock);
    drive(1, 12'h200, 1, 12'h200, 80'h7, 10'h3FF);
    #1;
    chk("coll_rd_ready", 80'(bus.rd_req_ready), 80'd1);
    chk("coll_wr_ready", 80'(bus.wr_req_ready), 80'd0);
    @(negedge clock);
    drive(0, 12'h000, 1, 12'h200, 80'h7, 10'h3FF);
    #1;
    chk("coll_wr_retry", 80'(bus.wr_req_ready), 80'd1);
    chk("coll_resp_valid", 80'(bus.rd_resp_valid), 80'd1);
    chk("coll_resp_old", bus.rd_resp_data, 80'h1);
    @(negedge clock);
    drive(1, 12'h200, 0, 12'h000, 80'h0, 10'h000);
    #1;
    chk("coll_reread_ready", 80'(bus.rd_req_ready), 80'd1);
    @(negedge clock);
    drive(0, 12'h000, 0, 12'h000, 80'h0, 10'h000);
    #1;
    chk("coll_reread_data", bus.rd_resp_data, 80'h7);

    // Reset right after a read grant drops the pending response at once.
    @(negedge clock);
    drive(1, 12'h123, 0, 12'h000, 80'h0, 10'h000);
    @(posedge clock);
    #2;
    chk("midrst_resp_before", 80'(bus.rd_resp_valid), 80'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 80'(bus.rd_resp_valid), 80'd0);
    chk("midrst_rd_ready", 80'(bus.rd_req_ready), 80'd0);
`ifdef ARRAY17_INIT_EN
    chk("midrst_init_done", 80'(init_done), 80'd0);
`else
    chk("midrst_init_done", 80'(init_done), 80'd1);
`endif
    drive(0, 12'h000, 0, 12'h000, 80'h0, 10'h000);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("postrst_resp_valid", 80'(bus.rd_resp_valid), 80'd0);
    wait_init("postrst");
    @(negedge clock);
    drive(1, 12'h123, 0, 12'h000, 80'h0, 10'h000);
    #1;
    chk("postrst_rd_ready", 80'(bus.rd_req_ready), 80'd1);
    @(negedge clock);
    drive(0, 12'h000, 0, 12'h000, 80'h0, 10'h000);
    #1;
    chk("postrst_resp_valid2", 80'(bus.rd_resp_valid), 80'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/array_17_arbiter.md
# array_17_arbiter

Single-port access controller for the 4096×80 byte-masked array macro. It arbitrates between one read requester and one write requester and drives the macro's single RW port. It realigns the macro's 1-cycle read latency into a response strobe. Optionally, it clears the whole array after reset before granting any request. It sits between the consuming pipeline stage and the array instance.

## Interface
- ADDR_W, 12, address width (DEPTH = 2^ADDR_W = 4096)
- DATA_W, 80, data width
- MASK_W, 10, byte-enable width (DATA_W/8)
- STARVE_MAX, 4, number of lost arbitration cycles after which a read wins; range 1..7
- clock  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  read request accepted this cycle
- rd_req_addr  in  ADDR_W  read address
- rd_resp_valid  out  1  read data valid; no backpressure
- rd_resp_data  out  DATA_W  read data
- wr_req_valid  in  1  write request valid
- wr_req_ready  out  1  write request accepted this cycle
- wr_req_addr  in  ADDR_W  write address
- wr_req_data  in  DATA_W  write data
- wr_req_mask  in  MASK_W  byte enables; bit i covers data[8i+7:8i]
- sram_addr  out  ADDR_W  to array RW0_addr
- sram_en  out  1  to array RW0_en
- sram_wmode  out  1  to array RW0_wmode (1 = write)
- sram_wmask  out  MASK_W  to array RW0_wmask
- sram_wdata  out  DATA_W  to array RW0_wdata
- sram_rdata  in  DATA_W  from array RW0_rdata
- init_done  out  1  array usable; requests can be granted

## Operation
- FSM states: INIT, RUN. Reset state is INIT when ARRAY17_INIT_EN is defined, RUN otherwise. INIT→RUN after the last clear write. RUN is terminal until reset.
- INIT:
  - sram_en=1, sram_wmode=1, sram_wmask all ones, sram_wdata=0, sram_addr=init_ptr.
  - init_ptr increments 0→DEPTH-1, one address per cycle.
  - Both readies are 0. init_done=0.
- RUN: one array operation per cycle at most. Grant logic is combinational from valids, state and starve_cnt. Ready may depend on valid.
  - Write only valid: write granted.
  - Read only valid: read granted.
  - Both valid: write wins unless starve_cnt == STARVE_MAX, in which case read wins.
  - Neither valid: sram_en=0.
- Write grant drives sram_en=1, sram_wmode=1 and passes addr/data/mask through unmodified.
- Read grant drives sram_en=1, sram_wmode=0 and sram_addr=rd_req_addr. sram_wmask and sram_wdata are 0 on reads and idle cycles.
- starve_cnt (3 bits, reset 0):
  - Increments, saturating at STARVE_MAX, each cycle rd_req_valid=1 without a read grant.
  - Clears on a read grant.
- Ordering: the array commits writes at the edge.
  - A read granted the cycle after a write to the same address returns the new data.
  - With both valid to the same address in the same cycle, the winner determines the result: write wins → read later sees new data; starved read wins → old data.
- init_done = (state == RUN).

## Timing
- Reset values: rd_resp_valid=0, starve_cnt=0, init_ptr=0. init_done=0 with the macro, 1 without. Readies are 0 while reset_n=0.
- Request-to-array is combinational (0 cycles).
- rd_resp_valid is registered: it is 1 in the cycle after a read grant, otherwise 0.
- rd_resp_data = sram_rdata, combinational pass-through. It is valid only while rd_resp_valid=1.
- Read throughput is 1 per cycle, and back-to-back reads produce back-to-back responses.
- INIT lasts exactly DEPTH cycles after reset release. The first grant is possible in cycle DEPTH.
- Reset mid-INIT restarts at init_ptr=0. Reset mid-read drops the pending response: rd_resp_valid is forced to 0 asynchronously.

## Configuration
- ARRAY17_INIT_EN defined:
  - INIT state and init_ptr are present.
  - The array reads as all-zero after init_done rises.
- ARRAY17_INIT_EN undefined:
  - No init_ptr; the FSM is reduced to RUN.
  - init_done is constant 1 after reset; array contents are undefined until written.
  - Requests are grantable in the first cycle after reset release.

## Test plan
- Init (macro on): release reset → init_done rises after 4096 cycles with 4096 zero writes, addresses 0..4095. A read of 0x0A5 then returns 80'h0.
- Write/read: write addr 0x123, data 80'hFFEE…, mask 10'h3FF. Next cycle read 0x123 → rd_resp_valid exactly one cycle later with matching data.
- Byte mask: write 0x010 with all-ones data and mask 10'h3FF. Then write all-zero data with mask 10'h001. Read returns 80'hFFFF_FFFF_FFFF_FFFF_FF00.
- Starvation (STARVE_MAX=4): both valid continuously → write granted cycles 0-3, read granted cycle 4, writes granted from cycle 5. Pattern repeats every 5 cycles.
- Same-address collision: write 0x200=80'h1 and read 0x200 in the same cycle with starve_cnt=0 → write first, read returns 80'h1. Repeat with starve_cnt=STARVE_MAX → read returns the previous contents.
- Reset mid-operation: assert reset_n=0 the cycle after a read grant → rd_resp_valid 0 immediately. With the macro, init restarts at address 0.
